noc_switch_xbar: RTL and testbench
==================================

// Module: noc_switch_xbar
// PURPOSE
//  Parametrised NUM_PORTS x NUM_PORTS router switch: next generation of the 5-port router crossbar.
//  Adds valid/ready flow control, per-output round-robin arbitration and wormhole packet locking.
//  Adds an optional registered output stage.
//  Sits between router input buffers/route compute (supply flit + dest) and output links.
//  Port index map for 5-port router: 0=L, 1=N, 2=E, 3=S, 4=W.
// PARAMETERS
//  DATA_WIDTH  8  flit payload width
//  NUM_PORTS   5  number of input ports and output ports (2..16)
//  SEL_W       3  dest field width; must satisfy 2**SEL_W >= NUM_PORTS
// PORTS
//  clk        in   1                     single clock, rising edge
//  rst        in   1                     asynchronous, active-high reset
//  in_data    in   NUM_PORTS*DATA_WIDTH  flit of input i at [i*DATA_WIDTH +: DATA_WIDTH]
//  in_dest    in   NUM_PORTS*SEL_W       requested output port of input i
//  in_last    in   NUM_PORTS             flit i is packet tail (single-flit packet: last=1)
//  in_valid   in   NUM_PORTS             input i presents a flit
//  in_ready   out  NUM_PORTS             input i flit consumed this cycle
//  out_data   out  NUM_PORTS*DATA_WIDTH  flit on output o
//  out_last   out  NUM_PORTS             tail marker on output o
//  out_valid  out  NUM_PORTS             output o holds a flit
//  out_ready  in   NUM_PORTS             downstream accepts output o
//  err_dest   out  NUM_PORTS             1-cycle pulse: input i flit dropped, dest >= NUM_PORTS
// BEHAVIOUR
//  - Request: req[o][i] = in_valid[i] && in_dest[i]==o. Each input targets at most one output.
//  - Per-output FSM: IDLE / LOCKED(owner). Per-output round-robin pointer ptr[o].
//  - IDLE: winner = first requesting i scanning from ptr[o]+1 (mod NUM_PORTS); ptr[o] <= winner on transfer.
//  - IDLE transfer with last=0 -> LOCKED(winner); with last=1 -> stay IDLE.
//  - LOCKED: only owner may transfer; other requesters stall (in_ready=0).
//  - LOCKED: owner transfer with last=1 -> IDLE. Owner valid=0 holds lock (bubble) and does not release.
//  - Slot free: free[o] = !out_valid[o] || out_ready[o].
//  - Transfer on o: winner/owner requests && free[o]; in_ready[winner]=1 same cycle.
//  - in_ready has a combinational path from in_valid/in_dest and out_ready; no combinational path to out_valid.
//  - Registered out (macro on): on transfer, out_data/out_last/out_valid load next edge; 1-cycle latency.
//  - Registered out: out_valid[o] clears on out_valid&&out_ready without a new transfer.
//  - Registered out: simultaneous drain + load -> back-to-back, one flit/cycle sustained per output.
//  - Registered out: data/last held stable while out_valid && !out_ready.
//  - Bad dest (in_dest[i] >= NUM_PORTS, in_valid[i]=1): in_ready[i]=1, flit discarded, err_dest[i]=1.
//  - err_dest is registered: pulse in the cycle after the drop. Lock state is unchanged.
//  - Output o idle (no flit): out_data=0, out_last=0.
//  - Reset (any time, including mid-packet): all FSMs IDLE, ptr[o]=NUM_PORTS-1 (input 0 highest priority first).
//  - Reset values: out_valid=0, out_data=0, out_last=0, err_dest=0, in_ready=0.
//  - Partial packet at reset is lost; sender must resend.
//  - U-turn (dest == own index) is legal and arbitrated like any request.
// CONFIGURATION
//  NOC_XBAR_OUT_REG_EN defined: registered output stage as above; latency 1 cycle.
//  NOC_XBAR_OUT_REG_EN undefined: out_* driven combinationally from granted input.
//    out_valid[o] = granted request; free[o] = out_ready[o]; latency 0.
//    FSM/pointer update on out_valid&&out_ready. err_dest remains registered.
// TESTING
//  Each test runs in both macro builds.
//  1 Single flit, in0 dest=2 last=1 data=8'hA5, out_ready=all 1
//    -> in_ready[0]=1 same cycle; out_valid[2]=1 data A5 last=1 next cycle (reg) / same cycle (comb).
//  2 in1 and in4 both dest=3, single-flit, held valid, data 11/44
//    -> out3 sequence 11,44,11,44; neither starves.
//  3 in2 sends 3-flit packet (C1,C2,C3 last) to port 0; in1 requests port 0 from cycle 1
//    -> out0 = C1,C2,C3 contiguous, then in1 flit; in_ready[1]=0 until C3 accepted.
//  4 Reg build, out3 holds 3C, out_ready[3]=0 for 4 cycles with in4 pending to port 3
//    -> out_data stable 3C, in_ready[4]=0; on release, 3C drains and the in4 flit follows next cycle.
//  5 in2 dest=7 valid 1 cycle -> in_ready[2]=1, no out_valid anywhere, err_dest[2]=1 for exactly 1 cycle after.
//  6 rst pulsed mid-packet (port 1 LOCKED)
//    -> out_valid=0 immediately; after release a new head from in3 to port 1 is granted.

Source files
------------

// File: rtl/noc_switch_xbar.sv
// rtl/noc_switch_xbar.sv - NUM_PORTS x NUM_PORTS wormhole router crossbar with round-robin output arbitration
//
// Purpose:
//   Connects router input ports (flit + destination from route compute) to output
//   links. Each output has a round-robin arbiter and an IDLE/LOCKED state. A packet
//   head locks the output to its input until the tail flit passes (wormhole).
//   Flits whose destination is not a real port are consumed and dropped, and are
//   flagged on err_dest one cycle later.
//   Port map for the 5-port router: 0=L, 1=N, 2=E, 3=S, 4=W.
//
// Build option:
//   NOC_XBAR_OUT_REG_EN defined   : registered output stage, 1-cycle latency.
//   NOC_XBAR_OUT_REG_EN undefined : out_* driven combinationally from the granted
//                                   input, 0-cycle latency.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   in_data    in   flit of input i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_dest    in   requested output of input i at [i*SEL_W +: SEL_W]
//   in_last    in   flit i is a packet tail
//   in_valid   in   input i presents a flit
//   in_ready   out  flit of input i consumed this cycle
//   out_data   out  flit on output o (zero when idle)
//   out_last   out  tail marker on output o (zero when idle)
//   out_valid  out  output o holds a flit
//   out_ready  in   downstream accepts output o
//   err_dest   out  one-cycle pulse: flit of input i dropped for a bad destination
module noc_switch_xbar #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_PORTS  = 5,
  parameter int SEL_W      = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_PORTS*SEL_W-1:0]      in_dest,
  input  logic [NUM_PORTS-1:0]            in_last,
  input  logic [NUM_PORTS-1:0]            in_valid,
  output logic [NUM_PORTS-1:0]            in_ready,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] out_data,
  output logic [NUM_PORTS-1:0]            out_last,
  output logic [NUM_PORTS-1:0]            out_valid,
  input  logic [NUM_PORTS-1:0]            out_ready,
  output logic [NUM_PORTS-1:0]            err_dest
);

  logic [SEL_W-1:0]      dest     [NUM_PORTS];
  logic [NUM_PORTS-1:0]  bad_dest;
  logic [SEL_W-1:0]      gnt      [NUM_PORTS];
  logic [NUM_PORTS-1:0]  has_req;
  logic [NUM_PORTS-1:0]  free;
  logic [NUM_PORTS-1:0]  xfer;
  logic [DATA_WIDTH-1:0] sel_data [NUM_PORTS];
  logic [NUM_PORTS-1:0]  sel_last;

  logic [NUM_PORTS-1:0]  locked;
  logic [SEL_W-1:0]      owner    [NUM_PORTS];
  logic [SEL_W-1:0]      ptr      [NUM_PORTS];

  // Request decode, arbitration and data select per output.
  always_comb begin
    int cand;
    cand = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      dest[i]     = in_dest[i*SEL_W +: SEL_W];
      bad_dest[i] = in_valid[i] && (int'(dest[i]) >= NUM_PORTS);
    end
    for (int o = 0; o < NUM_PORTS; o++) begin
      gnt[o]     = '0;
      has_req[o] = 1'b0;
      if (locked[o]) begin
        // Owner bubbles (valid=0) simply leave has_req low; the lock stays.
        gnt[o]     = owner[o];
        has_req[o] = in_valid[owner[o]] && (dest[owner[o]] == SEL_W'(o));
      end else begin
        // Scan from farthest to nearest so the first requester after ptr wins.
        for (int k = NUM_PORTS; k >= 1; k--) begin
          cand = int'(ptr[o]) + k;
          if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
          if (in_valid[cand] && (dest[cand] == SEL_W'(o))) begin
            gnt[o]     = SEL_W'(cand);
            has_req[o] = 1'b1;
          end
        end
      end
      sel_data[o] = '0;
      sel_last[o] = 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (gnt[o] == SEL_W'(i)) begin
          sel_data[o] = in_data[i*DATA_WIDTH +: DATA_WIDTH];
          sel_last[o] = in_last[i];
        end
      end
    end
  end

  // Transfer qualification and input handshake.
  always_comb begin
    logic hit;
    hit = 1'b0;
    for (int o = 0; o < NUM_PORTS; o++) begin
`ifdef NOC_XBAR_OUT_REG_EN
      free[o] = !out_valid[o] || out_ready[o];
`else
      free[o] = out_ready[o];
`endif
      xfer[o] = has_req[o] && free[o];
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      hit = 1'b0;
      for (int o = 0; o < NUM_PORTS; o++) begin
        if (xfer[o] && (gnt[o] == SEL_W'(i))) hit = 1'b1;
      end
      in_ready[i] = !rst && (bad_dest[i] || hit);
    end
  end

  // Per-output lock FSM and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_dest <= '0;
      locked   <= '0;
      for (int o = 0; o < NUM_PORTS; o++) begin
        owner[o] <= '0;
        ptr[o]   <= SEL_W'(NUM_PORTS - 1);
      end
    end else begin
      err_dest <= bad_dest;
      for (int o = 0; o < NUM_PORTS; o++) begin
        if (xfer[o]) begin
          ptr[o] <= gnt[o];
          if (locked[o]) begin
            if (sel_last[o]) locked[o] <= 1'b0;
          end else if (!sel_last[o]) begin
            locked[o] <= 1'b1;
            owner[o]  <= gnt[o];
          end
        end
      end
    end
  end

`ifdef NOC_XBAR_OUT_REG_EN
  // Output slot: load on transfer, clear on drain; holds while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= '0;
      out_data  <= '0;
      out_last  <= '0;
    end else begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        if (xfer[o]) begin
          out_valid[o]                          <= 1'b1;
          out_data[o*DATA_WIDTH +: DATA_WIDTH]  <= sel_data[o];
          out_last[o]                           <= sel_last[o];
        end else if (out_ready[o]) begin
          out_valid[o]                          <= 1'b0;
          out_data[o*DATA_WIDTH +: DATA_WIDTH]  <= '0;
          out_last[o]                           <= 1'b0;
        end
      end
    end
  end
`else
  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      out_valid[o]                         = has_req[o] && !rst;
      out_data[o*DATA_WIDTH +: DATA_WIDTH] = (has_req[o] && !rst) ? sel_data[o] : '0;
      out_last[o]                          = has_req[o] && !rst && sel_last[o];
    end
  end
`endif

endmodule

// File: tb/tb_noc_switch_xbar.sv
// tb/tb_noc_switch_xbar.sv - scoreboard bench for noc_switch_xbar (either output build)
`timescale 1ns/1ps
module tb_noc_switch_xbar;
  localparam int DW = 8;
  localparam int NP = 5;
  localparam int SW = 3;
`ifdef NOC_XBAR_OUT_REG_EN
  localparam bit REG = 1'b1;
`else
  localparam bit REG = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] port;
    logic [7:0] data;
    logic       last;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [NP*DW-1:0] in_data;
  logic [NP*SW-1:0] in_dest;
  logic [NP-1:0]    in_last;
  logic [NP-1:0]    in_valid;
  logic [NP-1:0]    in_ready;
  logic [NP*DW-1:0] out_data;
  logic [NP-1:0]    out_last;
  logic [NP-1:0]    out_valid;
  logic [NP-1:0]    out_ready;
  logic [NP-1:0]    err_dest;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  noc_switch_xbar #(.DATA_WIDTH(DW), .NUM_PORTS(NP), .SEL_W(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_dest   (in_dest),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_dest  (err_dest)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive(input int i, input logic v, input logic [2:0] d, input logic [7:0] x, input logic l);
    in_valid[i]         = v;
    in_dest[i*SW +: SW] = d;
    in_data[i*DW +: DW] = x;
    in_last[i]          = l;
  endtask

  task automatic push(input logic [3:0] p, input logic [7:0] x, input logic l);
    exp_t e;
    e.port = p;
    e.data = x;
    e.last = l;
    exp_q.push_back(e);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string tag);
    tick;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick;
    chk(tag, 64'(exp_q.size()), 64'h0);
  endtask

  // Scoreboard: every output handshake pops the oldest expected flit.
  always @(negedge clk) begin
    if (!rst) begin
      for (int o = 0; o < NP; o++) begin
        if (out_valid[o] && out_ready[o]) begin
          total++;
          assert (exp_q.size() != 0) else begin
            bad++;
            $error("FAIL sb_extra port=%0d data=%0h expected=none", o, out_data[o*DW +: DW]);
          end
          if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("sb_port", 64'(o), 64'(mon_e.port));
            chk("sb_data", 64'(out_data[o*DW +: DW]), 64'(mon_e.data));
            chk("sb_last", 64'(out_last[o]), 64'(mon_e.last));
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_data = '0; in_dest = '0; in_last = '0; in_valid = '0; out_ready = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_out_data",  64'(out_data),  64'h0);
    chk("rst_out_last",  64'(out_last),  64'h0);
    chk("rst_err_dest",  64'(err_dest),  64'h0);
    chk("rst_in_ready",  64'(in_ready),  64'h0);
    @(posedge clk); #1 rst = 1'b0;

    // 1: single flit in0 -> out2
    drive(0, 1'b1, 3'd2, 8'hA5, 1'b1); push(4'd2, 8'hA5, 1'b1);
    @(negedge clk);
    chk("t1_in_ready", 64'(in_ready), 64'h01);
    chk("t1_ov_same",  64'(out_valid), REG ? 64'h0 : 64'h04);
    tick;
    drive(0, 1'b0, 3'd0, 8'h00, 1'b0);
    @(negedge clk);
    chk("t1_ov_next",   64'(out_valid), REG ? 64'h04 : 64'h0);
    chk("t1_data_next", 64'(out_data[2*DW +: DW]), REG ? 64'hA5 : 64'h0);
    wait_drain("t1_drain");

    // 2: in1 and in4 contend for out3, round-robin alternation
    drive(1, 1'b1, 3'd3, 8'h11, 1'b1); drive(4, 1'b1, 3'd3, 8'h44, 1'b1);
    push(4'd3, 8'h11, 1'b1); push(4'd3, 8'h44, 1'b1);
    push(4'd3, 8'h11, 1'b1); push(4'd3, 8'h44, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t2_rdy", 64'({in_ready[4], in_ready[1]}), (k % 2 == 0) ? 64'h1 : 64'h2);
      tick;
    end
    drive(1, 1'b0, 3'd0, 8'h00, 1'b0); drive(4, 1'b0, 3'd0, 8'h00, 1'b0);
    wait_drain("t2_drain");

    // 3: wormhole lock of out0 by in2, in1 waits for the tail
    drive(2, 1'b1, 3'd0, 8'hC1, 1'b0);
    push(4'd0, 8'hC1, 1'b0); push(4'd0, 8'hC2, 1'b0); push(4'd0, 8'hC3, 1'b1); push(4'd0, 8'h1F, 1'b1);
    @(negedge clk);
    chk("t3_head_rdy", 64'(in_ready[2]), 64'h1);
    tick;
    drive(2, 1'b1, 3'd0, 8'hC2, 1'b0); drive(1, 1'b1, 3'd0, 8'h1F, 1'b1);
    @(negedge clk);
    chk("t3_body_rdy", 64'(in_ready[2:1]), 64'h2);
    tick;
    drive(2, 1'b1, 3'd0, 8'hC3, 1'b1);
    @(negedge clk);
    chk("t3_tail_rdy", 64'(in_ready[2:1]), 64'h2);
    tick;
    drive(2, 1'b0, 3'd0, 8'h00, 1'b0);
    @(negedge clk);
    chk("t3_next_rdy", 64'(in_ready[2:1]), 64'h1);
    tick;
    drive(1, 1'b0, 3'd0, 8'h00, 1'b0);
    wait_drain("t3_drain");

    // 4: backpressure on out3 with in4 pending
`ifdef NOC_XBAR_OUT_REG_EN
    out_ready[3] = 1'b0;
    drive(3, 1'b1, 3'd3, 8'h3C, 1'b1); push(4'd3, 8'h3C, 1'b1); push(4'd3, 8'h44, 1'b1);
    @(negedge clk);
    chk("t4_load_rdy", 64'(in_ready[3]), 64'h1);
    tick;
    drive(3, 1'b0, 3'd0, 8'h00, 1'b0); drive(4, 1'b1, 3'd3, 8'h44, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t4_stall_data",  64'(out_data[3*DW +: DW]), 64'h3C);
      chk("t4_stall_valid", 64'(out_valid[3]), 64'h1);
      chk("t4_stall_rdy",   64'(in_ready[4]), 64'h0);
      tick;
    end
    out_ready[3] = 1'b1;
    @(negedge clk);
    chk("t4_rel_rdy", 64'(in_ready[4]), 64'h1);
    tick;
    drive(4, 1'b0, 3'd0, 8'h00, 1'b0);
    @(negedge clk);
    chk("t4_follow_data",  64'(out_data[3*DW +: DW]), 64'h44);
    chk("t4_follow_valid", 64'(out_valid[3]), 64'h1);
`else
    out_ready[3] = 1'b0;
    drive(4, 1'b1, 3'd3, 8'h44, 1'b1); push(4'd3, 8'h44, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t4_stall_data",  64'(out_data[3*DW +: DW]), 64'h44);
      chk("t4_stall_valid", 64'(out_valid[3]), 64'h1);
      chk("t4_stall_rdy",   64'(in_ready[4]), 64'h0);
      tick;
    end
    out_ready[3] = 1'b1;
    @(negedge clk);
    chk("t4_rel_rdy", 64'(in_ready[4]), 64'h1);
    tick;
    drive(4, 1'b0, 3'd0, 8'h00, 1'b0);
`endif
    wait_drain("t4_drain");

    // 5: bad destination dropped and flagged
    drive(2, 1'b1, 3'd7, 8'h77, 1'b1);
    @(negedge clk);
    chk("t5_rdy",    64'(in_ready), 64'h04);
    chk("t5_ov",     64'(out_valid), 64'h0);
    chk("t5_err_0",  64'(err_dest), 64'h0);
    tick;
    drive(2, 1'b0, 3'd0, 8'h00, 1'b0);
    @(negedge clk);
    chk("t5_err_1",  64'(err_dest), 64'h04);
    chk("t5_ov_1",   64'(out_valid), 64'h0);
    tick;
    @(negedge clk);
    chk("t5_err_2",  64'(err_dest), 64'h0);
    tick;

    // 6: reset while out1 is locked by in1 (U-turn packet)
    drive(1, 1'b1, 3'd1, 8'h61, 1'b0); push(4'd1, 8'h61, 1'b0);
    @(negedge clk);
    chk("t6_head_rdy", 64'(in_ready[1]), 64'h1);
    tick;
    drive(1, 1'b0, 3'd1, 8'h00, 1'b0); drive(3, 1'b1, 3'd1, 8'h33, 1'b1);
    @(negedge clk);
    chk("t6_bubble_rdy", 64'(in_ready[3]), 64'h0);
    tick;
    out_ready[1] = 1'b0;
    drive(1, 1'b1, 3'd1, 8'h62, 1'b0);
    @(negedge clk);
    chk("t6_locked_rdy", 64'(in_ready[3]), 64'h0);
    tick;
    #1;
    chk("t6_pre_rst_ov", 64'(out_valid[1]), 64'h1);
    rst = 1'b1;
    #1;
    chk("t6_rst_ov",   64'(out_valid), 64'h0);
    chk("t6_rst_rdy",  64'(in_ready), 64'h0);
    chk("t6_rst_data", 64'(out_data), 64'h0);
    drive(1, 1'b0, 3'd0, 8'h00, 1'b0);
    out_ready[1] = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    push(4'd1, 8'h33, 1'b1);
    @(negedge clk);
    chk("t6_new_head_rdy", 64'(in_ready[3]), 64'h1);
    tick;
    drive(3, 1'b0, 3'd0, 8'h00, 1'b0);
    wait_drain("t6_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
